wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb2axip_pkg.sv | 14 +
 rtl/wb_flight_counter.sv | 28 ++
 rtl/wb_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/wb2axip_pkg.sv
// Shared definitions for the Wishbone arbitration blocks: grant-state encoding
// and owner identifiers used by the round-robin arbiter.
package wb2axip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/wb_flight_counter.sv
// Outstanding-request counter for a pipelined Wishbone master: counts accepted
// strobes minus returned acks, saturating at both ends.
module wb_flight_counter #(
    parameter int LGFLIGHT = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                inc,
    input  logic                dec,
    input  logic                clr,
    output logic [LGFLIGHT-1:0] count,
    output logic                full
);

    assign full = (count == {LGFLIGHT{1'b1}});

    // Simultaneous inc and dec cancel; an ack with nothing in flight is ignored.
    always_ff @(posedge i_clk) begin
        if (i_reset || clr) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-port round-robin arbiter sharing one pipelined Wishbone slave between
// masters A and B, with in-flight tracking and bus-error lockout.
module wb_rr_arbiter
    import wb2axip_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int LGFLIGHT = 3
) (
    input  logic            i_clk,
    input  logic            i_reset,
    // Master A
    input  logic            i_acyc,
    input  logic            i_astb,
    input  logic            i_awe,
    input  logic [AW-1:0]   i_aaddr,
    input  logic [DW-1:0]   i_adata,
    input  logic [DW/8-1:0] i_asel,
    output logic            o_astall,
    output logic            o_aack,
    output logic            o_aerr,
    output logic [DW-1:0]   o_adata,
    // Master B
    input  logic            i_bcyc,
    input  logic            i_bstb,
    input  logic            i_bwe,
    input  logic [AW-1:0]   i_baddr,
    input  logic [DW-1:0]   i_bdata,
    input  logic [DW/8-1:0] i_bsel,
    output logic            o_bstall,
    output logic            o_back,
    output logic            o_berr,
    output logic [DW-1:0]   o_bdata,
    // Shared slave
    output logic            o_mcyc,
    output logic            o_mstb,
    output logic            o_mwe,
    output logic [AW-1:0]   o_maddr,
    output logic [DW-1:0]   o_mdata,
    output logic [DW/8-1:0] o_msel,
    input  logic            i_mstall,
    input  logic            i_mack,
    input  logic            i_merr,
    input  logic [DW-1:0]   i_mdata
);

    arb_state_t          state, state_next;
    logic                last_owner, last_owner_next;
    logic                err_lock;
    logic                gnt_a, gnt_b;
    logic                owner_cyc, owner_stb, owner_stall;
    logic                full;
    logic [LGFLIGHT-1:0] nflight;
    logic                cnt_inc, cnt_dec, cnt_clr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            last_owner <= OWNER_B;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
        end
    end

    // On a tie from IDLE the master that did not own the bus last time wins.
    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        case (state)
            ST_IDLE: begin
                if (i_acyc && i_bcyc)
                    state_next = (last_owner == OWNER_B) ? ST_GNT_A : ST_GNT_B;
                else if (i_acyc)
                    state_next = ST_GNT_A;
                else if (i_bcyc)
                    state_next = ST_GNT_B;
            end
            ST_GNT_A: begin
                if (!i_acyc) begin
                    state_next      = i_bcyc ? ST_GNT_B : ST_IDLE;
                    last_owner_next = OWNER_A;
                end
            end
            ST_GNT_B: begin
                if (!i_bcyc) begin
                    state_next      = i_acyc ? ST_GNT_A : ST_IDLE;
                    last_owner_next = OWNER_B;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign gnt_a = (state == ST_GNT_A);
    assign gnt_b = (state == ST_GNT_B);

    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        if (gnt_a) begin
            owner_cyc = i_acyc;
            owner_stb = i_astb;
        end else if (gnt_b) begin
            owner_cyc = i_bcyc;
            owner_stb = i_bstb;
        end
    end

    assign o_mcyc = owner_cyc && !err_lock;
    assign o_mstb = owner_stb && o_mcyc && !full;

    // Request fields follow the owner; A's fields are presented while idle.
    assign o_mwe   = gnt_b ? i_bwe   : i_awe;
    assign o_maddr = gnt_b ? i_baddr : i_aaddr;
    assign o_mdata = gnt_b ? i_bdata : i_adata;
    assign o_msel  = gnt_b ? i_bsel  : i_asel;

    assign owner_stall = i_mstall || full || err_lock;
    assign o_astall    = gnt_a ? owner_stall : 1'b1;
    assign o_bstall    = gnt_b ? owner_stall : 1'b1;

    assign o_aack = i_mack && gnt_a && i_acyc && !err_lock;
    assign o_aerr = i_merr && gnt_a && i_acyc && !err_lock;
    assign o_back = i_mack && gnt_b && i_bcyc && !err_lock;
    assign o_berr = i_merr && gnt_b && i_bcyc && !err_lock;

    assign o_adata = i_mdata;
    assign o_bdata = i_mdata;

    // Once the slave errors, the owner is locked out until it ends its cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_lock <= 1'b0;
        end else if (o_mcyc && i_merr) begin
            err_lock <= 1'b1;
        end else if ((gnt_a || gnt_b) && !owner_cyc) begin
            err_lock <= 1'b0;
        end
    end

    assign cnt_inc = o_mstb && !i_mstall;
    assign cnt_dec = i_mack && (nflight != '0);
    assign cnt_clr = (state_next != state) || !o_mcyc || i_merr;

    wb_flight_counter #(
        .LGFLIGHT(LGFLIGHT)
    ) u_flight (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .inc    (cnt_inc),
        .dec    (cnt_dec),
        .clr    (cnt_clr),
        .count  (nflight),
        .full   (full)
    );

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a per-cycle vector table for grant and
// routing behaviour, plus hand sequences for saturation, errors and reset.
module tb_wb_rr_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LGFLIGHT = 3;

    localparam logic [AW-1:0]   A_ADDR = 12'h0A5;
    localparam logic [AW-1:0]   B_ADDR = 12'h15B;
    localparam logic [DW-1:0]   A_DATA = 32'h1111_AAAA;
    localparam logic [DW-1:0]   B_DATA = 32'h2222_BBBB;
    localparam logic [DW/8-1:0] A_SEL  = 4'b0011;
    localparam logic [DW/8-1:0] B_SEL  = 4'b1100;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_acyc, i_astb, i_awe, i_bcyc, i_bstb, i_bwe;
    logic [AW-1:0]   i_aaddr, i_baddr;
    logic [DW-1:0]   i_adata, i_bdata, i_mdata;
    logic [DW/8-1:0] i_asel, i_bsel;
    logic            i_mstall, i_mack, i_merr;
    logic            o_astall, o_aack, o_aerr, o_bstall, o_back, o_berr;
    logic [DW-1:0]   o_adata, o_bdata, o_mdata;
    logic            o_mcyc, o_mstb, o_mwe;
    logic [AW-1:0]   o_maddr;
    logic [DW/8-1:0] o_msel;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    wb_rr_arbiter #(.AW(AW), .DW(DW), .LGFLIGHT(LGFLIGHT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_acyc(i_acyc), .i_astb(i_astb), .i_awe(i_awe), .i_aaddr(i_aaddr),
        .i_adata(i_adata), .i_asel(i_asel), .o_astall(o_astall),
        .o_aack(o_aack), .o_aerr(o_aerr), .o_adata(o_adata),
        .i_bcyc(i_bcyc), .i_bstb(i_bstb), .i_bwe(i_bwe), .i_baddr(i_baddr),
        .i_bdata(i_bdata), .i_bsel(i_bsel), .o_bstall(o_bstall),
        .o_back(o_back), .o_berr(o_berr), .o_bdata(o_bdata),
        .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe), .o_maddr(o_maddr),
        .o_mdata(o_mdata), .o_msel(o_msel), .i_mstall(i_mstall),
        .i_mack(i_mack), .i_merr(i_merr), .i_mdata(i_mdata)
    );

    // stim: {rst, acyc, astb, bcyc, bstb, mstall, mack, merr}
    // outs: {mcyc, mstb, aack, back, aerr, berr, astall, bstall}
    typedef struct {
        logic [7:0] stim;
        logic [8:0] exp_out;
    } vec_t;

    vec_t vecs[16];
    logic [7:0] outs;
    assign outs = {o_mcyc, o_mstb, o_aack, o_back, o_aerr, o_berr, o_astall, o_bstall};

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] stim, input logic [DW-1:0] mdata);
        @(negedge i_clk);
        {i_reset, i_acyc, i_astb, i_bcyc, i_bstb, i_mstall, i_mack, i_merr} = stim;
        i_mdata = mdata;
        #1;
    endtask

    initial begin
        logic [DW-1:0] md;
        logic [48:0]   exp_mux;

        i_awe = 1'b1; i_aaddr = A_ADDR; i_adata = A_DATA; i_asel = A_SEL;
        i_bwe = 1'b0; i_baddr = B_ADDR; i_bdata = B_DATA; i_bsel = B_SEL;
        i_mdata = '0;

        // A single write from A, then ack routing and return to IDLE
        vecs[0]  = '{8'b0_1_1_0_0_0_0_0, 9'b000000110};
        vecs[1]  = '{8'b0_1_1_0_0_0_0_0, 9'b110000010};
        vecs[2]  = '{8'b0_1_0_0_0_0_1_0, 9'b101000010};
        vecs[3]  = '{8'b0_0_0_0_0_0_0_0, 9'b000000010};
        vecs[4]  = '{8'b0_0_0_0_0_0_0_0, 9'b000000110};
        // Tie from reset, direct handover to B, B error lockout, next tie to A
        vecs[5]  = '{8'b1_0_0_0_0_0_0_0, 9'b000000110};
        vecs[6]  = '{8'b0_1_0_1_0_0_0_0, 9'b000000110};
        vecs[7]  = '{8'b0_1_0_1_1_0_0_0, 9'b100000010};
        vecs[8]  = '{8'b0_0_0_1_1_0_0_0, 9'b000000010};
        vecs[9]  = '{8'b0_1_1_1_1_0_0_0, 9'b110000101};
        vecs[10] = '{8'b0_1_1_1_0_0_1_0, 9'b100100101};
        vecs[11] = '{8'b0_1_0_1_0_0_0_1, 9'b100001101};
        vecs[12] = '{8'b0_0_0_0_0_0_0_0, 9'b000000111};
        vecs[13] = '{8'b0_1_0_1_0_0_0_0, 9'b000000110};
        vecs[14] = '{8'b0_1_1_1_1_0_0_0, 9'b110000010};
        vecs[15] = '{8'b0_0_0_0_0_0_0_0, 9'b000000010};

        apply_stimulus(8'b1_0_0_0_0_0_0_0, '0);
        apply_stimulus(8'b1_0_0_0_0_0_0_0, '0);
        check_output("reset_outputs", 64'(outs), 64'(8'b00000011));

        for (int i = 0; i < 16; i++) begin
            md = 32'hD000_0000 + 32'(i);
            apply_stimulus(vecs[i].stim, md);
            check_output($sformatf("vec%0d_ctl", i), 64'(outs), 64'(vecs[i].exp_out[8:1]));
            exp_mux = vecs[i].exp_out[0] ? {i_bwe, B_SEL, B_ADDR, B_DATA}
                                         : {1'b1, A_SEL, A_ADDR, A_DATA};
            check_output($sformatf("vec%0d_mux", i), 64'({o_mwe, o_msel, o_maddr, o_mdata}), 64'(exp_mux));
            check_output($sformatf("vec%0d_rdata", i), {o_adata, o_bdata}, {md, md});
        end

        // Saturation: seven accepted, stalled when full, one ack frees a slot
        apply_stimulus(8'b1_0_0_0_0_0_0_0, '0);
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        check_output("sat_idle_stb", 64'(o_mstb), 64'(0));
        for (int k = 0; k < 7; k++) begin
            apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
            check_output($sformatf("sat_accept%0d", k), 64'({o_mstb, o_astall}), 64'(2'b10));
        end
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        check_output("sat_full_stall", 64'({o_mstb, o_astall}), 64'(2'b01));
        apply_stimulus(8'b0_1_1_0_0_0_1_0, '0);
        check_output("sat_ack_cycle", 64'({o_mstb, o_aack}), 64'(2'b01));
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        check_output("sat_eighth", 64'({o_mstb, o_astall}), 64'(2'b10));
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        check_output("sat_full_again", 64'(o_astall), 64'(1));
        apply_stimulus(8'b0_0_0_0_0_0_0_0, '0);

        // Bus error on the second of three requests
        apply_stimulus(8'b1_0_0_0_0_0_0_0, '0);
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
            check_output($sformatf("err_req%0d", k), 64'(o_mstb), 64'(1));
        end
        apply_stimulus(8'b0_1_0_0_0_0_1_0, '0);
        check_output("err_ack1", 64'({o_aack, o_aerr}), 64'(2'b10));
        apply_stimulus(8'b0_1_0_0_0_0_0_1, '0);
        check_output("err_pulse", 64'({o_aack, o_aerr}), 64'(2'b01));
        apply_stimulus(8'b0_1_0_0_0_0_1_0, '0);
        check_output("err_locked_ack", 64'({o_mcyc, o_aack, o_astall}), 64'(3'b001));
        apply_stimulus(8'b0_1_0_0_0_0_0_1, '0);
        check_output("err_locked_err", 64'({o_mcyc, o_aerr}), 64'(2'b00));
        apply_stimulus(8'b0_0_0_0_0_0_0_0, '0);
        check_output("err_drop_cyc", 64'({o_mcyc, o_astall}), 64'(2'b01));
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        check_output("err_unlocked", 64'({o_mcyc, o_mstb, o_astall}), 64'(3'b110));
        apply_stimulus(8'b0_0_0_0_0_0_0_0, '0);

        // Reset with two requests in flight, then a late ack and underflow guard
        apply_stimulus(8'b1_0_0_0_0_0_0_0, '0);
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        apply_stimulus(8'b1_1_1_0_0_0_0_0, '0);
        apply_stimulus(8'b0_1_1_0_0_0_1_0, '0);
        check_output("rst_mid_late_ack", 64'(outs), 64'(8'b00000011));
        apply_stimulus(8'b0_1_0_0_0_0_1_0, '0);
        check_output("ack_at_zero", 64'(o_aack), 64'(1));
        apply_stimulus(8'b0_1_1_0_0_0_0_0, '0);
        check_output("no_underflow", 64'({o_mstb, o_astall}), 64'(2'b10));
        apply_stimulus(8'b0_0_0_0_0_0_0_0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
